mmsp430_trace_arbiter: RTL and testbench
========================================

Name: mmsp430_trace_arbiter

Overview:
- Collects per-core instruction-execution trace events from NCORES MSP430 cores and buffers one event per core.
- Arbitrates between cores round-robin and serializes the granted event into 16-bit debug flits for the trace packetizer / debug NoC.
- Sits between the core trace taps and the Debug-on-Chip trace module.
- Counts events dropped while a core's buffer is full and reports the count in the next packet from that core.

Parameters:
- NCORES, 4, number of traced cores (1..16).
- DROPW, 8, width of the per-core saturating drop counter (at most 8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  capture enable; when 0, new trace events are ignored.
- trace_valid  in  NCORES  per-core event strobe; one event per asserted cycle.
- trace_pc  in  NCORES*32  per-core PC; core i occupies [32i+31:32i].
- trace_insn  in  NCORES*32  per-core instruction word.
- trace_flags  in  NCORES*4  per-core {jb,jal,jr,wben}.
- trace_wbreg  in  NCORES*5  per-core writeback register.
- trace_wbdata  in  NCORES*32  per-core writeback data.
- out_flit  out  16  flit data.
- out_valid  out  1  flit valid.
- out_ready  in  1  downstream ready.
- out_last  out  1  final flit of the packet.
- busy  out  1  high when any entry is pending or a packet is in flight.

Behaviour:
- Reset (sync, rst=1 at a clk edge): all pending bits 0, drop counters 0, rr pointer 0, FSM IDLE, out_valid=0, out_last=0, out_flit=0, busy=0. Reset mid-packet abandons the packet; no further flits of it are emitted.
- Capture, per core i, each cycle with enable=1 and trace_valid[i]=1:
  - If pending[i]=0, or the entry is granted this same cycle: latch pc/insn/flags/wbreg/wbdata and set pending[i].
  - Otherwise: drop the event; drop_cnt[i] increments, saturating at 2^DROPW-1.
- enable=0: no capture and no drop counting. Pending entries and in-flight packets still drain.
- Arbitration:
  - Occurs only in IDLE with at least one pending bit set.
  - Grant goes to the first pending core scanning from rr_ptr upward, wrapping modulo NCORES.
  - The granted entry is copied to the serializer register and pending is cleared in the grant cycle.
  - drop_cnt[g] is copied into the header and zeroed in the same cycle. A drop arriving in that same cycle makes the counter 1.
  - rr_ptr becomes g+1 mod NCORES. FSM moves to SEND with idx=0.
- SEND:
  - out_valid=1; out_flit = word[idx]; advance idx on out_valid&&out_ready.
  - out_flit holds stable while out_ready=0.
  - Word order:
    - 0: header {core_id[3:0], jb, jal, jr, wben, drop_cnt zero-extended to 8 bits}.
    - 1: pc[31:16].
    - 2: pc[15:0].
    - 3: insn[31:16].
    - 4: insn[15:0].
  - out_last=1 on the final word.
  - The handshake of the final word returns the FSM to IDLE with out_valid=0. This inserts one idle cycle between packets.
- Latency: event at cycle t with the FSM idle and no other pending entry → header flit valid at t+2 (capture at t, grant at t+1).
- busy = |pending or FSM≠IDLE.

Optional Feature:
- Macro: MMSP430_TRACE_WB_EN.
- Defined: when the captured wben=1, the packet appends three words after insn: {11'b0, wbreg}, wbdata[31:16], wbdata[15:0]. The packet is 8 flits with out_last on word 7. When wben=0, the packet is 5 flits.
- Undefined: trace_wbreg/trace_wbdata are ignored and not stored. Packets are always 5 flits; the wben flag is still reported in the header.

Test Plan:
- Core 1 event, pc=0x0000C012, insn=0x40314400, flags=4'b1000, out_ready=1 → flits 0x1800, 0x0000, 0xC012, 0x4031, 0x4400; out_last on the 5th flit; header valid 2 cycles after the strobe.
- Cores 0, 2, 3 strobe in the same cycle with rr_ptr=2 → packets emitted in core order 2, 3, 0; rr_ptr ends at 1.
- Core 0 strobes 4 consecutive cycles with out_ready=0 → first event sent, second buffered (it is captured in the grant cycle), 2 dropped. The next core-0 header low byte is 0x02.
- 300 drops on core 3 with out_ready held 0 → drop count saturates; next header for core 3 reads 0x30FF.
- out_ready toggled 1/0 every cycle mid-packet → each flit held stable while not accepted; no flit duplicated or skipped. Assert rst during word 2 → out_valid=0 next cycle, busy=0.
- With MMSP430_TRACE_WB_EN and wben=1, wbreg=5, wbdata=0x1234ABCD → 8 flits ending 0x0005, 0x1234, 0xABCD with out_last on the 8th. With wben=0 → 5 flits.

Source files
------------

// File: rtl/mmsp430_trace_arbiter.sv
`default_nettype none
//============================================================================
// Module  : mmsp430_trace_arbiter
// Brief   : Buffers one trace event per MSP430 core, arbitrates round-robin
//           and serializes the granted event into 16-bit debug flits.
//           Events hitting a full buffer are dropped and counted; the count
//           rides in the header of the next packet from that core.
// Config  : define MMSP430_TRACE_WB_EN to store writeback reg/data and
//           append three writeback words to packets whose wben flag is set.
// Rev     : 1.0 - initial release
//============================================================================
module mmsp430_trace_arbiter #(
  parameter int NCORES = 4,
  parameter int DROPW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NCORES-1:0]     trace_valid,
  input  logic [NCORES*32-1:0]  trace_pc,
  input  logic [NCORES*32-1:0]  trace_insn,
  input  logic [NCORES*4-1:0]   trace_flags,
  input  logic [NCORES*5-1:0]   trace_wbreg,
  input  logic [NCORES*32-1:0]  trace_wbdata,
  output logic [15:0]           out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int c_ptrw = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_idx, w_idx_nxt, w_last_idx;
  logic [c_ptrw-1:0] r_rr, w_gnt_idx;
  logic [NCORES-1:0] w_pend, w_gnt_oh;
  logic              w_gnt_any, w_grant;

  logic [31:0]       w_pc_arr    [NCORES];
  logic [31:0]       w_insn_arr  [NCORES];
  logic [3:0]        w_flags_arr [NCORES];
  logic [DROPW-1:0]  w_drop_arr  [NCORES];

  // Serializer snapshot of the granted entry
  logic [3:0]        r_core;
  logic [3:0]        r_flags;
  logic [7:0]        r_dcnt;
  logic [31:0]       r_pc;
  logic [31:0]       r_insn;

`ifdef MMSP430_TRACE_WB_EN
  logic [4:0]        w_wbreg_arr  [NCORES];
  logic [31:0]       w_wbdata_arr [NCORES];
  logic [4:0]        r_wbreg;
  logic [31:0]       r_wbdata;
`else
  // Writeback taps are not stored in this build.
  logic              w_unused_wb;
  assign w_unused_wb = ^{trace_wbreg, trace_wbdata};
`endif

  // Round-robin search: first pending core at or above rr pointer, wrapping.
  always_comb begin
    int j;
    j         = 0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    for (int k = 0; k < NCORES; k++) begin
      j = (int'(r_rr) + k) % NCORES;
      if (!w_gnt_any && w_pend[j]) begin
        w_gnt_any   = 1'b1;
        w_gnt_idx   = j[c_ptrw-1:0];
        w_gnt_oh[j] = 1'b1;
      end
    end
  end

  // A grant is only issued while the serializer is idle.
  assign w_grant = w_gnt_any && (r_state == ST_IDLE);

  generate
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
      logic             r_pend;
      logic [DROPW-1:0] r_drop;
      logic [31:0]      r_pc_e;
      logic [31:0]      r_insn_e;
      logic [3:0]       r_flags_e;
      logic             w_sel;
      logic             w_take;
      logic             w_drop;

      // The granted slot is freed this cycle, so it can accept a new event.
      assign w_sel  = w_grant && w_gnt_oh[gi];
      assign w_take = enable && trace_valid[gi] && (!r_pend || w_sel);
      assign w_drop = enable && trace_valid[gi] && !w_take;

      // Pending flag and saturating drop counter; grant hands the count off.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pend <= 1'b0;
          r_drop <= '0;
        end else begin
          if (w_take) begin
            r_pend <= 1'b1;
          end else if (w_sel) begin
            r_pend <= 1'b0;
          end
          if (w_sel) begin
            r_drop <= w_drop ? DROPW'(1) : '0;
          end else if (w_drop && (r_drop != {DROPW{1'b1}})) begin
            r_drop <= r_drop + DROPW'(1);
          end
        end
      end

      // Event payload latch for this core.
      always_ff @(posedge clk) begin
        if (w_take) begin
          r_pc_e    <= trace_pc[32*gi +: 32];
          r_insn_e  <= trace_insn[32*gi +: 32];
          r_flags_e <= trace_flags[4*gi +: 4];
        end
      end

      assign w_pend[gi]      = r_pend;
      assign w_pc_arr[gi]    = r_pc_e;
      assign w_insn_arr[gi]  = r_insn_e;
      assign w_flags_arr[gi] = r_flags_e;
      assign w_drop_arr[gi]  = r_drop;

`ifdef MMSP430_TRACE_WB_EN
      logic [4:0]  r_wbreg_e;
      logic [31:0] r_wbdata_e;

      // Writeback payload latch for this core.
      always_ff @(posedge clk) begin
        if (w_take) begin
          r_wbreg_e  <= trace_wbreg[5*gi +: 5];
          r_wbdata_e <= trace_wbdata[32*gi +: 32];
        end
      end

      assign w_wbreg_arr[gi]  = r_wbreg_e;
      assign w_wbdata_arr[gi] = r_wbdata_e;
`endif
    end
  endgenerate

  // FSM state, word index and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_grant) begin
        r_rr <= (w_gnt_idx == c_ptrw'(NCORES - 1)) ? '0 : w_gnt_idx + c_ptrw'(1);
      end
    end
  end

  // Snapshot the granted entry into the serializer at grant time.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_core  <= 4'(w_gnt_idx);
      r_flags <= w_flags_arr[w_gnt_idx];
      r_dcnt  <= 8'(w_drop_arr[w_gnt_idx]);
      r_pc    <= w_pc_arr[w_gnt_idx];
      r_insn  <= w_insn_arr[w_gnt_idx];
`ifdef MMSP430_TRACE_WB_EN
      r_wbreg  <= w_wbreg_arr[w_gnt_idx];
      r_wbdata <= w_wbdata_arr[w_gnt_idx];
`endif
    end
  end

`ifdef MMSP430_TRACE_WB_EN
  assign w_last_idx = r_flags[0] ? 3'd7 : 3'd4;
`else
  assign w_last_idx = 3'd4;
`endif

  // Next-state: grant moves to SEND, final handshake returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == ST_IDLE) begin
      if (w_gnt_any) begin
        w_state_nxt = ST_SEND;
        w_idx_nxt   = '0;
      end
    end else if (out_ready) begin
      if (r_idx == w_last_idx) begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt = r_idx + 3'd1;
      end
    end
  end

  // Flit mux; output is zero whenever nothing is being sent.
  always_comb begin
    out_valid = (r_state == ST_SEND);
    out_last  = out_valid && (r_idx == w_last_idx);
    out_flit  = '0;
    if (out_valid) begin
      case (r_idx)
        3'd0:    out_flit = {r_core, r_flags, r_dcnt};
        3'd1:    out_flit = r_pc[31:16];
        3'd2:    out_flit = r_pc[15:0];
        3'd3:    out_flit = r_insn[31:16];
        3'd4:    out_flit = r_insn[15:0];
`ifdef MMSP430_TRACE_WB_EN
        3'd5:    out_flit = {11'b0, r_wbreg};
        3'd6:    out_flit = r_wbdata[31:16];
        3'd7:    out_flit = r_wbdata[15:0];
`endif
        default: out_flit = '0;
      endcase
    end
  end

  assign busy = (|w_pend) || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mmsp430_trace_arbiter.sv
`default_nettype none
//============================================================================
// Module  : tb_mmsp430_trace_arbiter
// Brief   : Directed bench with a queue-based packet model for
//           mmsp430_trace_arbiter; honours MMSP430_TRACE_WB_EN.
// Rev     : 1.0 - initial release
//============================================================================
module tb_mmsp430_trace_arbiter;

  localparam int NC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [NC-1:0]    trace_valid;
  logic [NC*32-1:0] trace_pc;
  logic [NC*32-1:0] trace_insn;
  logic [NC*4-1:0]  trace_flags;
  logic [NC*5-1:0]  trace_wbreg;
  logic [NC*32-1:0] trace_wbdata;
  logic [15:0]      out_flit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  mmsp430_trace_arbiter #(.NCORES(NC), .DROPW(8)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_insn(trace_insn),
    .trace_flags(trace_flags), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: buffered events, drop counts, rr pointer, packet in flight.
  bit          m_pend [NC];
  logic [31:0] m_pc   [NC];
  logic [31:0] m_insn [NC];
  logic [3:0]  m_fl   [NC];
  logic [4:0]  m_wbr  [NC];
  logic [31:0] m_wbd  [NC];
  int          m_drop [NC];
  int          m_rr;
  logic [15:0] m_q[$];
  bit          model_on = 1'b0;

  // Log of flits the DUT handed over
  logic [15:0] acc_flit[$];
  bit          acc_last[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] flit_at(input int idx);
    if (idx < acc_flit.size()) return acc_flit[idx];
    return 16'hxxxx;
  endfunction

  function automatic logic last_at(input int idx);
    if (idx < acc_last.size()) return acc_last[idx];
    return 1'bx;
  endfunction

  // Model update at each active edge
  always @(posedge clk) begin
    bit pre [NC];
    int g;
    int j;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        m_pend[i] = 1'b0;
        m_drop[i] = 0;
      end
      m_rr = 0;
      m_q.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      if (out_valid && out_ready) begin
        acc_flit.push_back(out_flit);
        acc_last.push_back(out_last);
      end
      pre = m_pend;
      g = -1;
      if (m_q.size() == 0) begin
        for (int k = 0; k < NC; k++) begin
          j = (m_rr + k) % NC;
          if (g < 0 && m_pend[j]) g = j;
        end
        if (g >= 0) begin
          m_q.push_back({g[3:0], m_fl[g], 8'(m_drop[g])});
          m_q.push_back(m_pc[g][31:16]);
          m_q.push_back(m_pc[g][15:0]);
          m_q.push_back(m_insn[g][31:16]);
          m_q.push_back(m_insn[g][15:0]);
`ifdef MMSP430_TRACE_WB_EN
          if (m_fl[g][0]) begin
            m_q.push_back({11'b0, m_wbr[g]});
            m_q.push_back(m_wbd[g][31:16]);
            m_q.push_back(m_wbd[g][15:0]);
          end
`endif
          m_pend[g] = 1'b0;
          m_drop[g] = 0;
          m_rr = (g + 1) % NC;
        end
      end else if (out_ready) begin
        void'(m_q.pop_front());
      end
      for (int i = 0; i < NC; i++) begin
        if (enable && trace_valid[i]) begin
          if (!pre[i] || g == i) begin
            m_pend[i] = 1'b1;
            m_pc[i]   = trace_pc[32*i +: 32];
            m_insn[i] = trace_insn[32*i +: 32];
            m_fl[i]   = trace_flags[4*i +: 4];
            m_wbr[i]  = trace_wbreg[5*i +: 5];
            m_wbd[i]  = trace_wbdata[32*i +: 32];
          end else if (m_drop[i] < 255) begin
            m_drop[i]++;
          end
        end
      end
    end
  end

  // Per-cycle comparison of outputs against the model
  always @(negedge clk) begin
    bit ev;
    bit anyp;
    if (model_on) begin
      ev = (m_q.size() > 0);
      anyp = 1'b0;
      for (int i = 0; i < NC; i++) anyp = anyp | m_pend[i];
      chk("cyc_valid", 32'(out_valid), 32'(ev));
      chk("cyc_flit", 32'(out_flit), ev ? 32'(m_q[0]) : 32'd0);
      chk("cyc_last", 32'(out_last), 32'(ev && m_q.size() == 1));
      chk("cyc_busy", 32'(busy), 32'(anyp || ev));
    end
  end

  task automatic set_ev(input int c, input logic [31:0] pc, input logic [31:0] insn,
                        input logic [3:0] fl, input logic [4:0] wr, input logic [31:0] wd);
    trace_valid[c]             = 1'b1;
    trace_pc[32*c +: 32]       = pc;
    trace_insn[32*c +: 32]     = insn;
    trace_flags[4*c +: 4]      = fl;
    trace_wbreg[5*c +: 5]      = wr;
    trace_wbdata[32*c +: 32]   = wd;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lat;
    int n;
    rst = 1'b1; enable = 1'b1; out_ready = 1'b1;
    trace_valid = '0; trace_pc = '0; trace_insn = '0;
    trace_flags = '0; trace_wbreg = '0; trace_wbdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_flit", 32'(out_flit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single event on core 1: latency and flit content
    base = acc_flit.size();
    set_ev(1, 32'h0000C012, 32'h40314400, 4'b1000, 5'd0, 32'd0);
    @(negedge clk);
    trace_valid = '0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_hdr_now", 32'(out_flit), 32'h1800);
    wait_idle("t1_idle", 40);
    chk("t1_count", 32'(acc_flit.size() - base), 32'd5);
    chk("t1_w0", 32'(flit_at(base + 0)), 32'h1800);
    chk("t1_w1", 32'(flit_at(base + 1)), 32'h0000);
    chk("t1_w2", 32'(flit_at(base + 2)), 32'hC012);
    chk("t1_w3", 32'(flit_at(base + 3)), 32'h4031);
    chk("t1_w4", 32'(flit_at(base + 4)), 32'h4400);
    chk("t1_last3", 32'(last_at(base + 3)), 32'd0);
    chk("t1_last4", 32'(last_at(base + 4)), 32'd1);

    // Cores 0,2,3 together with rr pointer at 2 -> order 2,3,0
    base = acc_flit.size();
    set_ev(0, 32'h00001000, 32'h00001111, 4'b0010, 5'd0, 32'd0);
    set_ev(2, 32'h00002000, 32'h00002222, 4'b0100, 5'd0, 32'd0);
    set_ev(3, 32'h00003000, 32'h00003333, 4'b1000, 5'd0, 32'd0);
    @(negedge clk);
    trace_valid = '0;
    wait_idle("t2_idle", 100);
    chk("t2_hdr_a", 32'(flit_at(base + 0)), 32'h2400);
    chk("t2_hdr_b", 32'(flit_at(base + 5)), 32'h3800);
    chk("t2_hdr_c", 32'(flit_at(base + 10)), 32'h0200);
    // rr pointer now 1: core 1 wins over core 0
    base = acc_flit.size();
    set_ev(0, 32'h00000010, 32'h00000020, 4'b0000, 5'd0, 32'd0);
    set_ev(1, 32'h00000030, 32'h00000040, 4'b0000, 5'd0, 32'd0);
    @(negedge clk);
    trace_valid = '0;
    wait_idle("t2_rr_idle", 100);
    chk("t2_rr_first", 32'(flit_at(base + 0)), 32'h1000);
    chk("t2_rr_second", 32'(flit_at(base + 5)), 32'h0000);

    // Core 0 four back-to-back events with downstream stalled
    base = acc_flit.size();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_ev(0, 32'h000000A0 + 32'(k), 32'h0000BB00, 4'b0000, 5'd0, 32'd0);
      @(negedge clk);
    end
    trace_valid = '0;
    out_ready = 1'b1;
    wait_idle("t3_idle", 100);
    chk("t3_count", 32'(acc_flit.size() - base), 32'd10);
    chk("t3_hdr1", 32'(flit_at(base + 0)), 32'h0000);
    chk("t3_pc1", 32'(flit_at(base + 2)), 32'h00A0);
    chk("t3_hdr2", 32'(flit_at(base + 5)), 32'h0002);
    chk("t3_pc2", 32'(flit_at(base + 7)), 32'h00A1);

    // 300 drops on core 3 saturate the counter
    base = acc_flit.size();
    out_ready = 1'b0;
    set_ev(3, 32'h00000333, 32'h00000444, 4'b0000, 5'd0, 32'd0);
    repeat (302) @(negedge clk);
    trace_valid = '0;
    out_ready = 1'b1;
    wait_idle("t4_idle", 100);
    chk("t4_hdr1", 32'(flit_at(base + 0)), 32'h3000);
    chk("t4_hdr2", 32'(flit_at(base + 5)), 32'h30FF);

    // Toggling ready: each flit exactly once, in order
    base = acc_flit.size();
    set_ev(2, 32'h12345678, 32'h9ABCDEF0, 4'b0100, 5'd0, 32'd0);
    @(negedge clk);
    trace_valid = '0;
    n = 0;
    while (busy && n < 60) begin
      out_ready = ~out_ready;
      @(negedge clk);
      n++;
    end
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_count", 32'(acc_flit.size() - base), 32'd5);
    chk("t5_w0", 32'(flit_at(base + 0)), 32'h2400);
    chk("t5_w1", 32'(flit_at(base + 1)), 32'h1234);
    chk("t5_w2", 32'(flit_at(base + 2)), 32'h5678);
    chk("t5_w3", 32'(flit_at(base + 3)), 32'h9ABC);
    chk("t5_w4", 32'(flit_at(base + 4)), 32'hDEF0);

    // Reset while word 2 is on the output abandons the packet
    out_ready = 1'b0;
    set_ev(1, 32'h0000BEEF, 32'h11112222, 4'b0000, 5'd0, 32'd0);
    @(negedge clk);
    trace_valid = '0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_word2", 32'(out_flit), 32'h0000BEEF);
    base = acc_flit.size();
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_abandon", 32'(acc_flit.size() - base), 32'd0);

    // enable=0 ignores strobes
    enable = 1'b0;
    set_ev(2, 32'h00000001, 32'h00000002, 4'b0000, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    trace_valid = '0;
    @(negedge clk);
    chk("en0_busy", 32'(busy), 32'd0);
    enable = 1'b1;

    // Writeback words (feature build) or plain 5-flit packet
    base = acc_flit.size();
    set_ev(0, 32'h00000100, 32'h12345678, 4'b0001, 5'd5, 32'h1234ABCD);
    @(negedge clk);
    trace_valid = '0;
    wait_idle("t6_idle", 40);
    chk("t6_hdr", 32'(flit_at(base + 0)), 32'h0100);
`ifdef MMSP430_TRACE_WB_EN
    chk("t6_count", 32'(acc_flit.size() - base), 32'd8);
    chk("t6_w5", 32'(flit_at(base + 5)), 32'h0005);
    chk("t6_w6", 32'(flit_at(base + 6)), 32'h1234);
    chk("t6_w7", 32'(flit_at(base + 7)), 32'hABCD);
    chk("t6_last7", 32'(last_at(base + 7)), 32'd1);
    chk("t6_last4", 32'(last_at(base + 4)), 32'd0);
`else
    chk("t6_count", 32'(acc_flit.size() - base), 32'd5);
    chk("t6_last4", 32'(last_at(base + 4)), 32'd1);
`endif
    base = acc_flit.size();
    set_ev(0, 32'h00000200, 32'h87654321, 4'b0000, 5'd5, 32'h1234ABCD);
    @(negedge clk);
    trace_valid = '0;
    wait_idle("t6b_idle", 40);
    chk("t6b_count", 32'(acc_flit.size() - base), 32'd5);
    chk("t6b_last4", 32'(last_at(base + 4)), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
